jelly_axi4s_frame_normalizer: RTL

- Sits directly upstream of the AXI4-Stream image-processing wrapper, between the video input/DMA source and its input FIFO.
- Guarantees that every frame delivered downstream has exactly param_x_num × param_y_num pixels, with tuser[0] only on the first pixel and tlast only on each line's last pixel.
- Short lines and short frames are padded with param_fill. Over-long lines are trimmed. Pixels outside a frame are discarded.
- This keeps the downstream line buffers and blank insertion aligned when the source glitches.

---
 rtl/jelly_axi4s_frame_normalizer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/jelly_axi4s_frame_normalizer.sv
// Forces every AXI4-Stream frame to exactly x_num*y_num pixels (pad short lines/frames, trim long lines).
// Latency 1 clk input->output, 1 pixel/clk; input stalls while padding or while the output register is full.
module jelly_axi4s_frame_normalizer #(
  parameter int TUSER_WIDTH      = 1,
  parameter int TDATA_WIDTH      = 24,
  parameter int IMG_X_WIDTH      = 10,
  parameter int IMG_Y_WIDTH      = 9,
  parameter int INIT_PARAM_X_NUM = 640,
  parameter int INIT_PARAM_Y_NUM = 480
) (
  input  logic                   reset,
  input  logic                   clk,
  input  logic                   enable,
  output logic                   busy,
  input  logic [IMG_X_WIDTH-1:0] param_x_num,
  input  logic [IMG_Y_WIDTH-1:0] param_y_num,
  input  logic [TDATA_WIDTH-1:0] param_fill,
  output logic                   err_short_line,
  output logic                   err_long_line,
  output logic                   err_short_frame,
  input  logic [TUSER_WIDTH-1:0] s_axi4s_tuser,
  input  logic                   s_axi4s_tlast,
  input  logic [TDATA_WIDTH-1:0] s_axi4s_tdata,
  input  logic                   s_axi4s_tvalid,
  output logic                   s_axi4s_tready,
  output logic [TUSER_WIDTH-1:0] m_axi4s_tuser,
  output logic                   m_axi4s_tlast,
  output logic [TDATA_WIDTH-1:0] m_axi4s_tdata,
  output logic                   m_axi4s_tvalid,
  input  logic                   m_axi4s_tready
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAD_LINE,
    ST_SKIP,
    ST_PAD_FRAME
  } state_t;

  state_t                 state, state_next;
  logic [IMG_X_WIDTH-1:0] x, x_num, xmax;
  logic [IMG_Y_WIDTH-1:0] y, y_num, ymax;
  logic [TDATA_WIDTH-1:0] fill;
  logic                   out_free, x_end, y_end, frame_end, frame_top, s_sof;
  logic                   start, emit, emit_fill;
  logic                   set_short_line, set_long_line, set_short_frame;
  logic [TUSER_WIDTH-1:0] emit_user;

  assign out_free  = !m_axi4s_tvalid || m_axi4s_tready;
  assign xmax      = x_num - IMG_X_WIDTH'(1);
  assign ymax      = y_num - IMG_Y_WIDTH'(1);
  assign x_end     = (x == xmax);
  assign y_end     = (y == ymax);
  assign frame_end = x_end && y_end;
  assign frame_top = (x == '0) && (y == '0);
  assign s_sof     = s_axi4s_tvalid && s_axi4s_tuser[0];
  assign busy      = (state != ST_IDLE);

  // An SOF that must be kept for the next frame is held off with tready=0.
  always_comb begin
    state_next      = state;
    s_axi4s_tready  = 1'b0;
    start           = 1'b0;
    emit            = 1'b0;
    emit_fill       = 1'b0;
    set_short_line  = 1'b0;
    set_long_line   = 1'b0;
    set_short_frame = 1'b0;
    case (state)
      ST_IDLE: begin
        s_axi4s_tready = 1'b1;
        if (enable && s_sof) begin
          s_axi4s_tready = 1'b0;
          start          = 1'b1;
          state_next     = ST_RUN;
        end
      end
      ST_RUN: begin
        if (s_sof && !frame_top) begin
          set_short_frame = 1'b1;
          state_next      = ST_PAD_FRAME;
        end else begin
          s_axi4s_tready = out_free;
          if (s_axi4s_tvalid && out_free) begin
            emit = 1'b1;
            if (frame_end) begin
              state_next = ST_IDLE;
            end else if (s_axi4s_tlast && !x_end) begin
              set_short_line = 1'b1;
              state_next     = ST_PAD_LINE;
            end else if (x_end && !s_axi4s_tlast) begin
              set_long_line = 1'b1;
              state_next    = ST_SKIP;
            end
          end
        end
      end
      ST_PAD_LINE: begin
        if (out_free) begin
          emit      = 1'b1;
          emit_fill = 1'b1;
          if (x_end) state_next = y_end ? ST_IDLE : ST_RUN;
        end
      end
      ST_SKIP: begin
        if (s_sof) begin
          set_short_frame = 1'b1;
          state_next      = ST_PAD_FRAME;
        end else begin
          s_axi4s_tready = 1'b1;
          if (s_axi4s_tvalid && s_axi4s_tlast) state_next = ST_RUN;
        end
      end
      ST_PAD_FRAME: begin
        if (out_free) begin
          emit      = 1'b1;
          emit_fill = 1'b1;
          if (frame_end) state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // SOF is regenerated from the position; upper side-band bits pass through for real pixels only.
  always_comb begin
    emit_user    = emit_fill ? '0 : s_axi4s_tuser;
    emit_user[0] = frame_top;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      x               <= '0;
      y               <= '0;
      x_num           <= IMG_X_WIDTH'(INIT_PARAM_X_NUM);
      y_num           <= IMG_Y_WIDTH'(INIT_PARAM_Y_NUM);
      fill            <= '0;
      err_short_line  <= 1'b0;
      err_long_line   <= 1'b0;
      err_short_frame <= 1'b0;
      m_axi4s_tvalid  <= 1'b0;
      m_axi4s_tuser   <= '0;
      m_axi4s_tlast   <= 1'b0;
      m_axi4s_tdata   <= '0;
    end else begin
      state           <= state_next;
      err_short_line  <= set_short_line;
      err_long_line   <= set_long_line;
      err_short_frame <= set_short_frame;
      if (start) begin
        x_num <= param_x_num;
        y_num <= param_y_num;
        fill  <= param_fill;
        x     <= '0;
        y     <= '0;
      end else if (emit) begin
        if (x_end) begin
          x <= '0;
          y <= y_end ? '0 : y + IMG_Y_WIDTH'(1);
        end else begin
          x <= x + IMG_X_WIDTH'(1);
        end
      end
      if (emit) begin
        m_axi4s_tvalid <= 1'b1;
        m_axi4s_tuser  <= emit_user;
        m_axi4s_tlast  <= x_end;
        m_axi4s_tdata  <= emit_fill ? fill : s_axi4s_tdata;
      end else if (m_axi4s_tready) begin
        m_axi4s_tvalid <= 1'b0;
      end
    end
  end

endmodule
